// File: rtl/mmr_pkg.sv
// Shared types and constants for the matrix-multiply memory responder.
package mmr_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    HDR   = 2'd1,
    SERVE = 2'd2,
    DONE  = 2'd3
  } mmr_state_e;

  // host load selector
  localparam logic [1:0] LD_HDR = 2'd0;
  localparam logic [1:0] LD_A   = 2'd1;
  localparam logic [1:0] LD_B   = 2'd2;

  // header word indices
  localparam logic [1:0] HDR_M1_ROW = 2'd0;
  localparam logic [1:0] HDR_M1_COL = 2'd1;
  localparam logic [1:0] HDR_M2_COL = 2'd2;

endpackage

// File: rtl/mmr_ram.sv
// Simple array: one synchronous write port, one combinational read port, no reset.
module mmr_ram #(
  parameter int W  = 20,
  parameter int D  = 64,
  parameter int AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [D];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/mm_mem_responder.sv
// Memory-side responder for the matrix-multiply master: holds header/A/B, captures C.
// Protocol error checking and err_cnt are built only when MMR_ERRCHK_EN is defined.
module mm_mem_responder
  import mmr_pkg::*;
#(
  parameter int DATA_W  = 20,
  parameter int ACC_W   = 40,
  parameter int MAX_DIM = 8,
  parameter int CNT_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ld_en,
  input  logic [1:0]        ld_sel,
  input  logic [DATA_W-1:0] ld_i,
  input  logic [DATA_W-1:0] ld_j,
  input  logic [DATA_W-1:0] ld_data,
  input  logic [DATA_W-1:0] i,
  input  logic [DATA_W-1:0] j,
  input  logic              index,
  input  logic              read,
  input  logic              write,
  input  logic [ACC_W-1:0]  write_data,
  input  logic              finish,
  output logic [DATA_W-1:0] read_data,
  input  logic [CNT_W-1:0]  rb_addr,
  output logic [ACC_W-1:0]  rb_data,
  output logic              done,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int AW    = $clog2(MAX_DIM);
  localparam int DEPTH = MAX_DIM * MAX_DIM;
  localparam int DW    = $clog2(DEPTH);
  localparam int TW    = 2 * DATA_W;

  mmr_state_e        state;
  logic [DATA_W-1:0] m1_row, m1_col, m2_col;
  logic [1:0]        hdr_cnt;
  logic [AW-1:0]     exp_row, exp_col;

  logic is_rd, is_wr, is_hdr;
  assign is_rd  = read & ~write;
  assign is_wr  = write & ~read;
  assign is_hdr = read & write;

  // Host load path; header and A/B contents are deliberately not reset.
  logic          ld_ok, a_we, b_we;
  logic [DW-1:0] ld_addr;

  assign ld_ok   = (ld_i < DATA_W'(MAX_DIM)) && (ld_j < DATA_W'(MAX_DIM));
  assign ld_addr = DW'(ld_i[AW-1:0]) * DW'(MAX_DIM) + DW'(ld_j[AW-1:0]);
  assign a_we    = (state == LOAD) && ld_en && (ld_sel == LD_A) && ld_ok;
  assign b_we    = (state == LOAD) && ld_en && (ld_sel == LD_B) && ld_ok;

  always_ff @(posedge clk)
    if ((state == LOAD) && ld_en && (ld_sel == LD_HDR))
      case (ld_i[1:0])
        HDR_M1_ROW: m1_row <= ld_data;
        HDR_M1_COL: m1_col <= ld_data;
        HDR_M2_COL: m2_col <= ld_data;
        default: ;
      endcase

  // Master read path: stride-addressed, combinational.
  logic [DW-1:0]     rd_addr;
  logic [DATA_W-1:0] a_rd, b_rd;
  logic              rd_oor;

  assign rd_addr = DW'(i[AW-1:0]) * DW'(MAX_DIM) + DW'(j[AW-1:0]);

  mmr_ram #(.W(DATA_W), .D(DEPTH)) u_a (
    .clk(clk), .we(a_we), .waddr(ld_addr), .wdata(ld_data),
    .raddr(rd_addr), .rdata(a_rd)
  );

  mmr_ram #(.W(DATA_W), .D(DEPTH)) u_b (
    .clk(clk), .we(b_we), .waddr(ld_addr), .wdata(ld_data),
    .raddr(rd_addr), .rdata(b_rd)
  );

  // A is m1_row x m1_col, B is m1_col x m2_col.
  always_comb begin
    rd_oor = (i >= DATA_W'(MAX_DIM)) || (j >= DATA_W'(MAX_DIM));
    if (index) rd_oor = rd_oor || (i >= m1_col) || (j >= m2_col);
    else       rd_oor = rd_oor || (i >= m1_row) || (j >= m1_col);
  end

  always_comb begin
    read_data = '0;
    case (state)
      HDR:
        if (is_hdr)
          case (i[1:0])
            HDR_M1_ROW: read_data = m1_row;
            HDR_M1_COL: read_data = m1_col;
            HDR_M2_COL: read_data = m2_col;
            default:    read_data = '0;
          endcase
      SERVE:
        if (is_rd && !rd_oor) read_data = index ? b_rd : a_rd;
      default: ;
    endcase
  end

  // Result capture into C, row-major with stride m2_col.
  logic             c_we, last_wr, col_wrap;
  logic [DW-1:0]    c_waddr;
  logic [ACC_W-1:0] c_rd;
  logic [CNT_W-1:0] wr_nxt;
  logic [TW-1:0]    target;

  assign c_we     = (state == SERVE) && is_wr;
  assign c_waddr  = DW'(exp_row) * DW'(m2_col) + DW'(exp_col);
  assign wr_nxt   = wr_cnt + CNT_W'(1);
  assign target   = TW'(m1_row) * TW'(m2_col);
  assign last_wr  = c_we && (target == TW'(wr_nxt));
  assign col_wrap = (DATA_W'(exp_col) == (m2_col - DATA_W'(1)));

  mmr_ram #(.W(ACC_W), .D(DEPTH)) u_c (
    .clk(clk), .we(c_we), .waddr(c_waddr), .wdata(write_data),
    .raddr(rb_addr[DW-1:0]), .rdata(c_rd)
  );

  assign rb_data = (rb_addr < CNT_W'(DEPTH)) ? c_rd : '0;

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state   <= LOAD;
      done    <= 1'b0;
      wr_cnt  <= '0;
      exp_row <= '0;
      exp_col <= '0;
      hdr_cnt <= '0;
    end else begin
      case (state)
        LOAD:
          if (start) state <= HDR;
        HDR:
          if (is_hdr) begin
            hdr_cnt <= hdr_cnt + 2'd1;
            if (hdr_cnt == 2'd2) state <= SERVE;
          end
        SERVE:
          if (c_we) begin
            wr_cnt <= wr_nxt;
            if (col_wrap) begin
              exp_col <= '0;
              exp_row <= exp_row + AW'(1);
            end else begin
              exp_col <= exp_col + AW'(1);
            end
            if (last_wr) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        DONE:
          if (start) begin
            state   <= HDR;
            done    <= 1'b0;
            wr_cnt  <= '0;
            exp_row <= '0;
            exp_col <= '0;
            hdr_cnt <= '0;
          end
        default: state <= LOAD;
      endcase
    end

`ifdef MMR_ERRCHK_EN
  logic err_now, first_done;

  // Any number of simultaneous violations counts once.
  always_comb begin
    err_now = 1'b0;
    case (state)
      LOAD:    err_now = read | write;
      HDR:     err_now = is_wr;
      SERVE:   err_now = (is_rd && rd_oor) || (is_wr && (i != DATA_W'(exp_row)));
      DONE:    err_now = write || (first_done && !finish);
      default: err_now = 1'b0;
    endcase
    if (finish && (state != DONE)) err_now = 1'b1;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      err_cnt    <= '0;
      first_done <= 1'b0;
    end else begin
      first_done <= last_wr;
      if (err_now && (err_cnt != '1)) err_cnt <= err_cnt + CNT_W'(1);
    end
`else
  logic unused_chk;
  assign unused_chk = &{1'b0, finish};
  assign err_cnt    = '0;
`endif

endmodule

// File: tb/tb_mm_mem_responder.sv
// Randomized self-checking bench: the bench plays host and master, a matrix model predicts C.
module tb_mm_mem_responder;

  localparam int DATA_W  = 20;
  localparam int ACC_W   = 40;
  localparam int MAX_DIM = 8;
  localparam int CNT_W   = 7;

  logic              clk = 1'b0;
  logic              reset, start, ld_en;
  logic [1:0]        ld_sel;
  logic [DATA_W-1:0] ld_i, ld_j, ld_data, i, j;
  logic              index, read, write, finish;
  logic [ACC_W-1:0]  write_data;
  logic [DATA_W-1:0] read_data;
  logic [CNT_W-1:0]  rb_addr;
  logic [ACC_W-1:0]  rb_data;
  logic              done;
  logic [CNT_W-1:0]  wr_cnt, err_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int exp_err = 0;
  int m1r, m1c, m2c;
  logic [DATA_W-1:0] ma [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0] mb [MAX_DIM][MAX_DIM];
  logic [ACC_W-1:0]  expc [MAX_DIM*MAX_DIM];

  mm_mem_responder #(
    .DATA_W(DATA_W), .ACC_W(ACC_W), .MAX_DIM(MAX_DIM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_i(ld_i), .ld_j(ld_j), .ld_data(ld_data), .i(i), .j(j), .index(index),
    .read(read), .write(write), .write_data(write_data), .finish(finish),
    .read_data(read_data), .rb_addr(rb_addr), .rb_data(rb_data), .done(done),
    .wr_cnt(wr_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int hdrv(input int h);
    return (h == 0) ? m1r : ((h == 1) ? m1c : m2c);
  endfunction

  task automatic do_reset();
    finish = 1'b0;
    reset  = 1'b1;
    #3;
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_wr_cnt", 64'(wr_cnt), 64'(0));
    chk("rst_err_cnt", 64'(err_cnt), 64'(0));
    exp_err = 0;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic ld(input logic [1:0] sel, input int li, input int lj, input logic [DATA_W-1:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_i = DATA_W'(li); ld_j = DATA_W'(lj); ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic load_all();
    ld(2'd0, 0, 0, DATA_W'(m1r));
    ld(2'd0, 1, 0, DATA_W'(m1c));
    ld(2'd0, 2, 0, DATA_W'(m2c));
    for (int r = 0; r < m1r; r++)
      for (int k = 0; k < m1c; k++) ld(2'd1, r, k, ma[r][k]);
    for (int k = 0; k < m1c; k++)
      for (int c = 0; c < m2c; c++) ld(2'd2, k, c, mb[k][c]);
  endtask

  task automatic rand_mats(input int r1, input int c1, input int c2);
    m1r = r1; m1c = c1; m2c = c2;
    for (int r = 0; r < MAX_DIM; r++)
      for (int c = 0; c < MAX_DIM; c++) begin
        ma[r][c] = DATA_W'($urandom());
        mb[r][c] = DATA_W'($urandom());
      end
  endtask

  // start, then the master's three header reads
  task automatic begin_run();
    start = 1'b1;
    tick();
    start  = 1'b0;
    finish = 1'b0;
    chk("start_done", 64'(done), 64'(0));
    chk("start_wr_cnt", 64'(wr_cnt), 64'(0));
    for (int h = 0; h < 3; h++) begin
      i = DATA_W'(h); read = 1'b1; write = 1'b1;
      #1 chk("hdr_read", 64'(read_data), 64'(hdrv(h)));
      tick();
    end
    read = 1'b0; write = 1'b0;
    #1 chk("idle_read_data", 64'(read_data), 64'(0));
  endtask

  task automatic rd(input bit idx, input int ri, input int rj, input logic [DATA_W-1:0] e, input string tag);
    index = idx; i = DATA_W'(ri); j = DATA_W'(rj); read = 1'b1; write = 1'b0;
    #1 chk(tag, 64'(read_data), 64'(e));
    tick();
    read = 1'b0;
  endtask

  task automatic wr(input int ri, input logic [ACC_W-1:0] d);
    i = DATA_W'(ri); write = 1'b1; read = 1'b0; write_data = d;
    tick();
    write = 1'b0;
  endtask

  // master: read operands, compute from the model, write row-major results
  task automatic serve(input int stop_after, input bit inject);
    int n;
    longint acc;
    n = 0;
    for (int r = 0; r < m1r; r++)
      for (int c = 0; c < m2c; c++) begin
        if (n == stop_after) return;
        acc = 0;
        for (int k = 0; k < m1c; k++) begin
          rd(1'b0, r, k, ma[r][k], "rd_a");
          rd(1'b1, k, c, mb[k][c], "rd_b");
          acc += longint'($signed(ma[r][k])) * longint'($signed(mb[k][c]));
        end
        expc[n] = acc[ACC_W-1:0];
        if (n == m1r * m2c - 1) chk("done_early", 64'(done), 64'(0));
        if (inject && n == 0) begin
          rd(1'b0, 9, 0, '0, "oor_dim_read");
          rd(1'b1, 0, m2c, '0, "oor_hdr_read");
          wr(1, expc[0]);
`ifdef MMR_ERRCHK_EN
          exp_err += 3;
`endif
        end else begin
          wr(r, expc[n]);
        end
        n++;
      end
    finish = 1'b1;
    chk("done", 64'(done), 64'(1));
    chk("wr_cnt", 64'(wr_cnt), 64'(m1r * m2c));
  endtask

  task automatic check_c();
    for (int n = 0; n < m1r * m2c; n++) begin
      rb_addr = CNT_W'(n);
      #1 chk("c_readback", 64'(rb_data), 64'(expc[n]));
    end
    chk("err_cnt", 64'(err_cnt), 64'(exp_err));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_sel = '0; ld_i = '0; ld_j = '0;
    ld_data = '0; i = '0; j = '0; index = 1'b0; read = 1'b0; write = 1'b0;
    finish = 1'b0; write_data = '0; rb_addr = '0;
    tick();
    do_reset();

    // 2x2 directed product
    m1r = 2; m1c = 2; m2c = 2;
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    load_all();
    begin_run();
    serve(99, 1'b0);
    check_c();
    rb_addr = CNT_W'(3);
    #1 chk("c11_const", 64'(rb_data), 64'(50));

    // restart from DONE keeps err_cnt
    begin_run();
    serve(99, 1'b0);
    check_c();

    // reset after 2 of 4 writes, rerun without reloading A/B
    begin_run();
    serve(2, 1'b0);
    chk("partial_wr_cnt", 64'(wr_cnt), 64'(2));
    do_reset();
    begin_run();
    serve(99, 1'b0);
    check_c();

    // 1x1 signed: -1 * 3
    do_reset();
    m1r = 1; m1c = 1; m2c = 1;
    ma[0][0] = 20'hFFFFF; mb[0][0] = 20'd3;
    load_all();
    begin_run();
    serve(99, 1'b0);
    check_c();
    rb_addr = '0;
    #1 chk("neg_const", 64'(rb_data), 64'h00_FFFF_FFFF_FD);

    // protocol violations: bad row on first write, out-of-range reads
    do_reset();
    rand_mats(2, 2, 2);
    load_all();
    begin_run();
    serve(99, 1'b1);
    check_c();

    // random shapes and values
    for (int t = 0; t < 4; t++) begin
      do_reset();
      rand_mats(int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      load_all();
      begin_run();
      serve(99, 1'b0);
      check_c();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mm_mem_responder.md
Name: mm_mem_responder

Overview:
Memory-side responder for the matrix-multiply master's read/write bus. It holds the dimension header and matrices A and B, which the host preloads. It serves the master's reads combinationally, captures the 40-bit result words into matrix C in row-major order, and checks write ordering and the finish pulse. It sits between the host/testbench loader and the matrix-multiply core; the host reads C back after done.

Parameters:
DATA_W, 20, element and index width on the bus
ACC_W, 40, result word width
MAX_DIM, 8, maximum rows/cols of any matrix; storage stride is MAX_DIM
CNT_W, 7, width of the write counter and the error counter (holds up to MAX_DIM*MAX_DIM)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse: LOAD -> HDR
ld_en  in  1  host load strobe, honoured only in LOAD
ld_sel  in  2  0=header, 1=A, 2=B, 3=ignored
ld_i  in  DATA_W  row (or header word index when ld_sel=0)
ld_j  in  DATA_W  column
ld_data  in  DATA_W  value to store
i  in  DATA_W  master row address
j  in  DATA_W  master column address
index  in  1  0=A, 1=B
read  in  1  master read strobe
write  in  1  master write strobe
write_data  in  ACC_W  result word
finish  in  1  master completion flag
read_data  out  DATA_W  combinational response
rb_addr  in  CNT_W  host readback address into C (row-major)
rb_data  out  ACC_W  C[rb_addr], combinational
done  out  1  all results captured
wr_cnt  out  CNT_W  results captured so far
err_cnt  out  CNT_W  protocol errors (saturating)

Behaviour:
- Interface: reset reset, asynchronous, active-high; clock clk.
- Reset values: state=LOAD, done=0, wr_cnt=0, err_cnt=0, exp_row=0, exp_col=0, hdr_cnt=0.
- Header, A and B contents survive reset. C is not cleared on reset; only its count restarts.
- States (shared encoding): LOAD, HDR, SERVE, DONE.
- LOAD:
  - ld_en writes hdr[ld_i[1:0]] (0=m1_row, 1=m1_col, 2=m2_col), A[ld_i][ld_j] or B[ld_i][ld_j].
  - read_data=0.
  - start -> HDR.
  - Any read or write strobe in LOAD counts as an error.
- HDR:
  - A cycle with read=1 and write=1 is a header read; read_data=hdr[i[1:0]] combinationally.
  - hdr_cnt increments on each header read; the third header read -> SERVE.
  - A write-only cycle in HDR counts as an error.
- SERVE, read-only (read=1, write=0):
  - read_data = index ? B[i][j] : A[i][j], zero latency, pure combinational from i/j/index.
  - Out-of-range access (i or j >= MAX_DIM, or beyond the header dimensions) returns 0 and counts an error.
- SERVE, write-only (write=1, read=0):
  - C[exp_row*m2_col+exp_col] <= write_data on the clock edge. wr_cnt++.
  - If i != exp_row, count an error; the data is still captured.
  - exp_col wraps at m2_col-1 and exp_row increments on the wrap.
  - The write that makes wr_cnt == m1_row*m2_col -> DONE.
- read=0 and write=0: idle, read_data=0.
- DONE:
  - done=1. Further writes are ignored and count as errors.
  - finish is expected high on the cycle after entry (the master registers it). If finish=1 in any state other than DONE, count an error.
  - start in DONE -> HDR: clears wr_cnt, exp_row, exp_col, done and hdr_cnt; err_cnt is kept.
- Simultaneous events:
  - start together with ld_en in LOAD: the load is performed and the state changes.
  - err_cnt saturates at all-ones; if two error conditions occur in one cycle, it increments by 1.
- Reset mid-SERVE: returns to LOAD immediately; the partial C contents remain readable but are stale.
- Sign: stored values are raw bits. No extension is done here; the master sign-extends.

Optional Feature:
MMR_ERRCHK_EN
- Defined: all error checks above are active and err_cnt counts.
- Undefined: no checking logic; err_cnt tied to 0.
  - Out-of-range reads still return 0.
  - Out-of-range read addresses still resolve to the stride index, so MAX_DIM must bound them.

Decomposition:
- Package mmr_pkg: state enum (LOAD/HDR/SERVE/DONE), ld_sel constants (LD_HDR=0, LD_A=1, LD_B=2), header index constants.
- Sub-module mmr_ram: parameterised width/depth array, one synchronous write port and one combinational read port. Instantiated three times: A and B at DATA_W, C at ACC_W.

Test Plan:
- Load hdr={2,2,2}, A=[[1,2],[3,4]], B=[[5,6],[7,8]]; start; run master -> C=[[19,22],[43,50]], done=1, wr_cnt=4, err_cnt=0, finish seen the cycle after the last write.
- A=[[20'hFFFFF]] (-1), B=[[3]], hdr={1,1,1} -> C[0]=40'hFFFFFFFFFD; read_data=20'hFFFFF during the index=0 read.
- Drive a write with i=1 while exp_row=0 -> data stored at C[0], err_cnt=1 (MMR_ERRCHK_EN defined); err_cnt=0 when undefined.
- In SERVE read A with i=9, MAX_DIM=8 -> read_data=0, err_cnt+1.
- Assert reset after 2 of 4 writes -> state LOAD, wr_cnt=0, done=0; A/B retained; restart produces the correct C again.
- From DONE, pulse start and rerun -> done drops, then rises again after 4 writes; err_cnt unchanged.
